// File: rtl/prog_loader_if.sv
// Handshake and program-memory write bus between the host byte stream and prog_loader.
// The slave modport is the loader's view; master is the host/memory side.
interface prog_loader_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 18
);
    logic               i_start;
    logic [7:0]         i_rx_data;
    logic               i_rx_valid;
    logic               o_rx_ready;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic [INSTR_W-1:0] o_mem_data;
    logic               o_mem_we;
    logic               o_cpu_hold;
    logic               o_done;
    logic               o_error;
    logic [15:0]        o_words_loaded;

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_rx_ready, o_mem_addr, o_mem_data, o_mem_we,
        output o_cpu_hold, o_done, o_error, o_words_loaded
    );

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_rx_ready, o_mem_addr, o_mem_data, o_mem_we,
        input  o_cpu_hold, o_done, o_error, o_words_loaded
    );
endinterface

// File: rtl/prog_loader.sv
// Assembles 3-byte, 18-bit instructions from a byte stream and writes them to program memory,
// holding the CPU until a full image is in place. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR byte.
module prog_loader #(
    parameter int ADDR_W    = 16,
    parameter int INSTR_W   = 18,
    parameter int BASE_ADDR = 0
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    prog_loader_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        B0,
        B1,
        B2,
        WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam longint            MAX_WORDS = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

    // Where a load goes once every word is written (or the count was zero).
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t FINISH = CHK;
`else
    localparam state_t FINISH = DONE;
`endif

    state_t             state_q, state_d;
    logic               ready_q, we_q, hold_q, done_q, error_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] data_q;
    logic [15:0]        count_q, words_q;
    logic [1:0]         hiBits_q;
    logic [7:0]         midByte_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         chkSum_q;
`endif

    logic        accept;
    logic [15:0] lenFull;
    logic [15:0] wordsInc;

    function automatic logic isRxState(input state_t s);
        case (s)
            LEN_HI, LEN_LO, B0, B1, B2: isRxState = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK:                        isRxState = 1'b1;
`endif
            default:                    isRxState = 1'b0;
        endcase
    endfunction

    assign accept   = bus.i_rx_valid && ready_q;
    assign lenFull  = {count_q[15:8], bus.i_rx_data};
    assign wordsInc = words_q + 16'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (bus.i_start) state_d = LEN_HI;
            LEN_HI: if (accept) state_d = LEN_LO;
            LEN_LO: if (accept) begin
                if (64'(lenFull) > MAX_WORDS) state_d = ERROR;
                else if (lenFull == 16'd0)    state_d = FINISH;
                else                          state_d = B0;
            end
            B0:     if (accept) state_d = (bus.i_rx_data[7:2] != 6'd0) ? ERROR : B1;
            B1:     if (accept) state_d = B2;
            B2:     if (accept) state_d = WRITE;
            WRITE:  state_d = (wordsInc == count_q) ? FINISH : B0;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK:    if (accept) state_d = (bus.i_rx_data == chkSum_q) ? DONE : ERROR;
`endif
            DONE, ERROR: if (bus.i_start) state_d = LEN_HI;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            addr_q    <= BASE;
            data_q    <= '0;
            count_q   <= '0;
            words_q   <= '0;
            hiBits_q  <= '0;
            midByte_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chkSum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= isRxState(state_d);
            we_q    <= (state_d == WRITE);
            case (state_q)
                IDLE, DONE, ERROR: if (bus.i_start) begin
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    hold_q  <= 1'b1;
                    addr_q  <= BASE;
                    words_q <= '0;
                end
                LEN_HI: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    chkSum_q <= '0;
`endif
                    if (accept) count_q[15:8] <= bus.i_rx_data;
                end
                LEN_LO: if (accept) count_q[7:0] <= bus.i_rx_data;
                B0: if (accept) begin
                    hiBits_q <= bus.i_rx_data[1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
                    chkSum_q <= chkSum_q ^ bus.i_rx_data;
`endif
                end
                B1: if (accept) begin
                    midByte_q <= bus.i_rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chkSum_q  <= chkSum_q ^ bus.i_rx_data;
`endif
                end
                B2: if (accept) begin
                    data_q <= INSTR_W'({hiBits_q, midByte_q, bus.i_rx_data});
`ifdef PROG_LOADER_CHECKSUM_EN
                    chkSum_q <= chkSum_q ^ bus.i_rx_data;
`endif
                end
                WRITE: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    words_q <= wordsInc;
                end
                default: ;
            endcase
            if (state_d == DONE) begin
                hold_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (state_d == ERROR) error_q <= 1'b1;
        end
    end

    assign bus.o_rx_ready     = ready_q;
    assign bus.o_mem_we       = we_q;
    assign bus.o_mem_addr     = addr_q;
    assign bus.o_mem_data     = data_q;
    assign bus.o_cpu_hold     = hold_q;
    assign bus.o_done         = done_q;
    assign bus.o_error        = error_q;
    assign bus.o_words_loaded = words_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program-ROM fetch path: receives a byte stream over a valid/ready handshake and assembles 18-bit instructions.
- Writes each instruction into program memory at consecutive addresses.
- Holds the CPU (instruction pointer frozen) from reset until a complete, valid image has been written.
- Sits between the host/serial front-end and the program memory's write port.

Parameters:
ADDR_W, 16, program memory address width
INSTR_W, 18, instruction width (fixed encoding: 3 bytes per word, upper 6 bits of first byte must be 0)
BASE_ADDR, 0, address of first word written

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset_n  in  1  reset, synchronous, active-low
i_start  in  1  begin (or restart) a load; sampled in IDLE, DONE, ERROR
i_rx_data  in  8  incoming byte
i_rx_valid  in  1  i_rx_data valid
o_rx_ready  out  1  loader can accept a byte this cycle
o_mem_addr  out  ADDR_W  program memory write address
o_mem_data  out  INSTR_W  program memory write data, MSB first
o_mem_we  out  1  write strobe, one cycle per word
o_cpu_hold  out  1  1 = CPU instruction pointer held
o_done  out  1  image loaded, sticky
o_error  out  1  load failed, sticky
o_words_loaded  out  16  words written in current load

Behaviour:
- Reset (i_reset_n=0 at clock edge) sets the following values:
  - state IDLE
  - o_rx_ready=0, o_mem_we=0
  - o_mem_addr=BASE_ADDR, o_mem_data=0
  - o_cpu_hold=1, o_done=0, o_error=0, o_words_loaded=0
  - internal count=0
- Reset mid-load behaves identically; memory already written is not erased.
- Byte accepted only on a cycle with i_rx_valid=1 and o_rx_ready=1.
  - o_rx_ready=1 in LEN_HI, LEN_LO, B0, B1, B2 (and CHK); 0 in IDLE, WRITE, DONE, ERROR.
  - o_rx_ready is a registered state decode; it does not depend on i_rx_valid.
- States and transitions:
  - IDLE: i_start=1 -> LEN_HI.
  - LEN_HI: accepted byte -> count[15:8]; -> LEN_LO.
  - LEN_LO: accepted byte -> count[7:0]. Next state:
    - ERROR if count > 2^ADDR_W - BASE_ADDR;
    - DONE if count==0 (CHK if enabled);
    - otherwise B0.
  - B0: byte[7:2] must be 0, else ERROR. byte[1:0] -> two MSBs of instruction; -> B1.
  - B1: byte -> instruction bits 15..8; -> B2.
  - B2: byte -> instruction bits 7..0; -> WRITE.
  - WRITE: single cycle with o_mem_we=1 and stable o_mem_addr/o_mem_data. Next edge:
    - o_mem_addr+1 and o_words_loaded+1;
    - if new o_words_loaded==count -> DONE (CHK if enabled); else -> B0.
  - DONE: o_cpu_hold=0, o_done=1.
  - ERROR: o_cpu_hold=1, o_error=1.
  - Exiting DONE or ERROR: i_start=1 restarts the load:
    - clears o_done and o_error, sets o_cpu_hold=1;
    - o_mem_addr=BASE_ADDR, o_words_loaded=0;
    - -> LEN_HI.
- i_start is ignored in all other states.
- Latency: last byte of word accepted at edge N -> o_mem_we high during cycle N+1.
- Minimum 4 cycles per word.
- o_mem_data holds last written word between writes.
- Address never wraps: the count check guarantees the final address ≤ 2^ADDR_W-1.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - running XOR of every accepted B0/B1/B2 byte, cleared at LEN_HI;
  - after the last WRITE (or LEN_LO with count 0), state CHK accepts one byte;
  - equal to running XOR -> DONE, else -> ERROR.
- Not defined: CHK state and XOR register are absent; transitions go straight to DONE.

Test Plan:
- Basic load:
  - stimulus: reset, i_start, bytes 00 02 01 23 45 02 AB CD;
  - required: exactly two o_mem_we pulses, addr0=0x12345 and addr1=0x2ABCD;
  - then o_done=1, o_cpu_hold=0, o_words_loaded=2.
- Backpressure:
  - stimulus: same stream with i_rx_valid low for 3 cycles between every byte;
  - required: identical writes;
  - o_rx_ready=0 during WRITE, and a byte presented then is not consumed until B0.
- Format error:
  - stimulus: bytes 00 01 04;
  - required: o_error=1, o_cpu_hold=1, no o_mem_we pulse;
  - a following i_start plus a valid stream recovers to o_done=1.
- Empty and overflow:
  - count 00 00 -> o_done=1 with no writes (with CHECKSUM_EN, checksum byte 00 is required).
  - BASE_ADDR=16'hFFFF with count 00 02 -> o_error=1 immediately after LEN_LO.
- Checksum (CHECKSUM_EN):
  - basic-load stream followed by 03 -> o_done=1;
  - followed by 04 -> o_error=1, o_cpu_hold=1.
- Reset mid-load:
  - stimulus: assert i_reset_n=0 after 4 accepted bytes;
  - required: all outputs return to reset values on that edge;
  - a subsequent full load writes from BASE_ADDR correctly.
